// File: rtl/fifo_serial_pkg.sv
// Shared types and helpers for the FIFO-drain serial transmitter.
// State encoding, parity modes and frame sizing.
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_e;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityEven = 1;

    // Bits on the line per frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned width,
                                               input int unsigned parity);
        return 32'd2 + width + ((parity == ParityEven) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/fifo_serial_baud.sv
// Bit-time generator: counts 0..DIV-1 and flags the last cycle of each bit.
// restart_i forces the count back to zero so every state begins a full bit.
module fifo_serial_baud #(
    parameter int unsigned DIV = 16
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic restart_i,
    output logic bit_end_o
);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == CntW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and sends each as an async serial frame:
// start bit, LSB-first data, optional even parity, stop bit.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIV    = 16,
    parameter int unsigned PARITY = ParityNone
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_read_o,
    output logic             txd_o,
    output logic             busy_o,
    output logic             frame_done_o
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             bit_end;
    logic             restart;
    logic             stop_end;
    logic             pop;

    fifo_serial_baud #(
        .DIV(DIV)
    ) u_baud (
        .clk_i    (clk_i),
        .clr_i    (clr_i),
        .restart_i(restart),
        .bit_end_o(bit_end)
    );

    assign stop_end = (state_q == StStop) && bit_end;
    // Gated by clr_i so a held reset never strobes the FIFO.
    assign pop      = enable_i && !fifo_empty_i && !clr_i &&
                      ((state_q == StIdle) || stop_end);
    assign restart  = (state_d != state_q) || (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (pop) begin
            state_d   = StStart;
            shift_d   = fifo_data_i;
            par_d     = ^fifo_data_i;
            bit_cnt_d = '0;
        end else if (bit_end) begin
            case (state_q)
                StStart: state_d = StData;
                StData: begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CntW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == ParityEven) ? StPar : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StPar:   state_d = StStop;
                StStop:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // txd is registered from the next state so the line lines up with state_q.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            StPar:   txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
        end
    end

    assign fifo_read_o  = pop;
    assign txd_o        = txd_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = stop_end;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: one DUT without parity, one with even parity, each fed by
// a small show-ahead FIFO model; frames checked bit by bit against hand tables.
module tb_fifo_serial_tx;
    localparam int DIV = 16;

    typedef struct {
        int          sel;
        logic [7:0]  word;
        logic [10:0] exp;    // line bits, index 0 = start bit
        int          nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en  = 1'b0;
    logic       empty [2];
    logic [7:0] data  [2];
    logic       rd    [2];
    logic       txd   [2];
    logic       busy  [2];
    logic       fd    [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         total = 0;
    int         bad   = 0;
    vec_t       vecs  [6];

    always #5 clk = ~clk;

    fifo_serial_tx #(.WIDTH(8), .DIV(DIV), .PARITY(0)) u_dut0 (
        .clk_i       (clk),
        .clr_i       (clr),
        .enable_i    (en),
        .fifo_empty_i(empty[0]),
        .fifo_data_i (data[0]),
        .fifo_read_o (rd[0]),
        .txd_o       (txd[0]),
        .busy_o      (busy[0]),
        .frame_done_o(fd[0])
    );

    fifo_serial_tx #(.WIDTH(8), .DIV(DIV), .PARITY(1)) u_dut1 (
        .clk_i       (clk),
        .clr_i       (clr),
        .enable_i    (en),
        .fifo_empty_i(empty[1]),
        .fifo_data_i (data[1]),
        .fifo_read_o (rd[1]),
        .txd_o       (txd[1]),
        .busy_o      (busy[1]),
        .frame_done_o(fd[1])
    );

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh();
        empty[0] = (q0.size() == 0);
        data[0]  = (q0.size() != 0) ? q0[0] : 8'h00;
        empty[1] = (q1.size() == 0);
        data[1]  = (q1.size() != 0) ? q1[0] : 8'h00;
    endtask

    task automatic push(input int sel, input logic [7:0] w);
        if (sel == 0) q0.push_back(w);
        else q1.push_back(w);
        refresh();
        #1;
    endtask

    // One clock: pop the FIFO model on the edge if read was high, settle at negedge.
    task automatic step();
        logic       r0, r1;
        logic [7:0] dummy;
        r0 = rd[0];
        r1 = rd[1];
        @(posedge clk);
        if (r0 && q0.size() != 0) dummy = q0.pop_front();
        if (r1 && q1.size() != 0) dummy = q1.pop_front();
        #1 refresh();
        @(negedge clk);
    endtask

    // Expects the word already queued with its read strobe visible now.
    task automatic check_frame(input vec_t v, input string tag);
        int s        = v.sel;
        int len      = v.nbits * DIV;
        int busy_cnt = 0;
        int done_at  = -1;
        int extra_rd = 0;
        chk({tag, "_pop"}, rd[s], 1);
        for (int c = 1; c <= len + 4; c++) begin
            step();
            if (busy[s]) busy_cnt++;
            if (fd[s] && done_at < 0) done_at = c;
            if (rd[s]) extra_rd++;
            if (c <= len && (c - 1) % DIV == DIV / 2)
                chk($sformatf("%s_txd_bit%0d", tag, (c - 1) / DIV), txd[s],
                    v.exp[(c-1)/DIV]);
        end
        chk({tag, "_busy_len"}, busy_cnt, len);
        chk({tag, "_done_at"}, done_at, len);
        chk({tag, "_extra_rd"}, extra_rd, 0);
        chk({tag, "_idle_txd"}, txd[s], 1);
    endtask

    initial begin : main
        int   bad_idle;
        int   rd_t [$];
        int   fd_t [$];
        int   busy_cnt;
        int   gaps;
        int   n_rd;
        int   done_at;
        vec_t v;

        vecs[0] = '{0, 8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[1] = '{0, 8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}, 10};
        vecs[2] = '{0, 8'h81, {1'b0, 1'b1, 8'h81, 1'b0}, 10};
        vecs[3] = '{1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11};
        vecs[4] = '{1, 8'h03, {1'b1, 1'b0, 8'h03, 1'b0}, 11};
        vecs[5] = '{1, 8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11};

        refresh();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_txd%0d", s), txd[s], 1);
            chk($sformatf("rst_busy%0d", s), busy[s], 0);
            chk($sformatf("rst_done%0d", s), fd[s], 0);
            chk($sformatf("rst_rd%0d", s), rd[s], 0);
        end

        // Released with empty FIFOs: the line must stay idle.
        en  = 1'b1;
        clr = 1'b0;
        #1;
        bad_idle = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int s = 0; s < 2; s++)
                if (txd[s] !== 1'b1 || busy[s] !== 1'b0 || fd[s] !== 1'b0 || rd[s] !== 1'b0)
                    bad_idle++;
        end
        chk("empty_idle", bad_idle, 0);

        foreach (vecs[i]) begin
            push(vecs[i].sel, vecs[i].word);
            check_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: three words queued together.
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        chk("b2b_pop0", rd[0], 1);
        busy_cnt = 0;
        gaps     = 0;
        for (int c = 1; c <= 500; c++) begin
            step();
            if (rd[0]) rd_t.push_back(c);
            if (fd[0]) fd_t.push_back(c);
            if (busy[0]) busy_cnt++;
            else if (c <= 480) gaps++;
            if (c == 25) chk("b2b_w0_bit0", txd[0], 0);
            if (c == 185) chk("b2b_w1_bit0", txd[0], 1);
            if (c == 345) chk("b2b_w2_bit0", txd[0], 0);
            if (c == 377) chk("b2b_w2_bit2", txd[0], 1);
        end
        chk("b2b_pops", rd_t.size(), 2);
        chk("b2b_pop1_at", (rd_t.size() > 0) ? rd_t[0] : -1, 160);
        chk("b2b_pop2_at", (rd_t.size() > 1) ? rd_t[1] : -1, 320);
        chk("b2b_dones", fd_t.size(), 3);
        chk("b2b_done3_at", (fd_t.size() > 2) ? fd_t[2] : -1, 480);
        chk("b2b_busy_len", busy_cnt, 480);
        chk("b2b_busy_gaps", gaps, 0);

        // Enable dropped mid data bit with a second word waiting.
        push(0, 8'h11);
        push(0, 8'h22);
        chk("en_pop1", rd[0], 1);
        n_rd    = 0;
        done_at = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (c == 24) begin
                en = 1'b0;
                #1;
            end
            if (rd[0]) n_rd++;
            if (fd[0] && done_at < 0) done_at = c;
        end
        chk("en_no_pop", n_rd, 0);
        chk("en_done_at", done_at, 160);
        chk("en_idle_busy", busy[0], 0);
        chk("en_idle_txd", txd[0], 1);
        en = 1'b1;
        #1;
        v = '{0, 8'h22, {1'b0, 1'b1, 8'h22, 1'b0}, 10};
        check_frame(v, "en_resume");

        // Reset in the middle of the data bits.
        push(0, 8'h55);
        chk("clr_pop", rd[0], 1);
        for (int c = 1; c <= 40; c++) step();
        chk("clr_pre_busy", busy[0], 1);
        clr = 1'b1;
        #1;
        chk("clr_txd", txd[0], 1);
        chk("clr_busy", busy[0], 0);
        push(0, 8'hA5);
        chk("clr_no_pop", rd[0], 0);
        step();
        step();
        chk("clr_hold_txd", txd[0], 1);
        chk("clr_hold_busy", busy[0], 0);
        clr = 1'b0;
        #1;
        check_frame(vecs[0], "clr_fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
